// File: rtl/fifo_pop_skid_pkg.sv
// Shared constants and helpers for the FIFO pop-side skid stage.
// Holds default widths, skid depth and the credit check used by the top level.
package fifo_pop_skid_pkg;

  localparam int DEF_DATA_WIDTH = 65;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int SKID_DEPTH     = 2;
  localparam int OCC_WIDTH      = $clog2(SKID_DEPTH + 1);

  typedef logic [OCC_WIDTH-1:0] occ_t;

  localparam occ_t OCC_ZERO = occ_t'(0);
  localparam occ_t OCC_ONE  = occ_t'(1);
  localparam occ_t OCC_FULL = occ_t'(SKID_DEPTH);

  // Per-cycle events derived from the FIFO return path and the consumer handshake.
  typedef struct packed {
    logic accept;
    logic pop;
    logic overflow;
    logic stray;
  } evt_t;

  // True when a read issued now still fits once every in-flight word has landed.
  function automatic logic has_room(input occ_t occ, input logic inflight, input logic pop);
    logic [OCC_WIDTH:0] credit;
    credit = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight};
    credit = credit - {{OCC_WIDTH{1'b0}}, pop};
    return credit < (OCC_WIDTH + 1)'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_pop_skid_skid_buf2.sv
// Two-entry in-order buffer: entry 0 is always the head, entry 1 the tail behind it.
// Head only changes on pop or on a write into an empty buffer, so it holds while stalled.
module skid_buf2
  import fifo_pop_skid_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] ent0_q;
  logic [DATA_WIDTH-1:0] ent1_q;
  occ_t                  occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= OCC_ZERO;
    end else if (flush) begin
      occ_q <= OCC_ZERO;
    end else begin
      unique case ({wr, pop})
        2'b10: begin
          if (occ_q == OCC_ZERO) begin
            ent0_q <= wr_data;
          end else if (occ_q == OCC_ONE) begin
            ent1_q <= wr_data;
          end
          if (occ_q != OCC_FULL) begin
            occ_q <= occ_q + OCC_ONE;
          end
        end
        2'b01: begin
          ent0_q <= ent1_q;
          if (occ_q != OCC_ZERO) begin
            occ_q <= occ_q - OCC_ONE;
          end
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands directly behind the surviving one.
          if (occ_q == OCC_FULL) begin
            ent0_q <= ent1_q;
            ent1_q <= wr_data;
          end else begin
            ent0_q <= wr_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head = ent0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_pop_skid.sv
// Pop-side skid stage for a FIFO with one-cycle read latency: issues reads on credit, presents a valid/ready head.
// Latency 2 cycles read_en -> Valid_out; Ready_in low stalls the head and stops reads once 2 words are owed.
module fifo_pop_skid
  import fifo_pop_skid_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n_in,
  input  logic                  Flush_in,
  input  logic                  Fifo_empty_in,
  input  logic [DATA_WIDTH-1:0] Fifo_data_in,
  input  logic                  Fifo_valid_in,
  output logic                  Fifo_read_en_out,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Valid_out,
  input  logic                  Ready_in,
  output logic [CNT_WIDTH-1:0]  Count_out,
  output logic                  Err_out
);

  logic                 run_q;
  logic                 inflight_q;
  logic                 flush_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 err_q;
  occ_t                 occ;
  evt_t                 evt;

  assign Valid_out = (occ != OCC_ZERO);

  // Returns are dropped during a flush and the cycle after it, since they belong to pre-flush reads.
  always_comb begin
    evt     = '0;
    evt.pop = Valid_out & Ready_in & ~Flush_in;
    if (Fifo_valid_in && !Flush_in && !flush_q) begin
      if (inflight_q) begin
        if ((occ == OCC_FULL) && !evt.pop) begin
          evt.overflow = 1'b1;
        end else begin
          evt.accept = 1'b1;
        end
      end else begin
        evt.stray = 1'b1;
      end
    end
    Fifo_read_en_out = run_q & ~Fifo_empty_in & ~Flush_in & has_room(occ, inflight_q, evt.pop);
  end

  // run_q keeps reads off until the first edge after reset release.
  always_ff @(posedge Clk or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      flush_q    <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= Fifo_read_en_out;
      flush_q    <= Flush_in;
      if (evt.pop) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
      if (evt.overflow || evt.stray) begin
        err_q <= 1'b1;
      end
    end
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk     (Clk),
    .rst_n   (Rst_n_in),
    .flush   (Flush_in),
    .wr      (evt.accept),
    .wr_data (Fifo_data_in),
    .pop     (evt.pop),
    .head    (Data_out),
    .occ     (occ)
  );

  assign Count_out = count_q;
  assign Err_out   = err_q;

endmodule

// File: tb/tb_fifo_pop_skid.sv
// Bench for fifo_pop_skid: emulates the upstream FIFO and checks outputs against a queue model every cycle.
module tb_fifo_pop_skid;

  localparam int DW = 65;
  localparam int CW = 32;

  logic          Clk;
  logic          Rst_n_in;
  logic          Flush_in;
  logic          Fifo_empty_in;
  logic [DW-1:0] Fifo_data_in;
  logic          Fifo_valid_in;
  logic          Fifo_read_en_out;
  logic [DW-1:0] Data_out;
  logic          Valid_out;
  logic          Ready_in;
  logic [CW-1:0] Count_out;
  logic          Err_out;

  fifo_pop_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .Clk              (Clk),
    .Rst_n_in         (Rst_n_in),
    .Flush_in         (Flush_in),
    .Fifo_empty_in    (Fifo_empty_in),
    .Fifo_data_in     (Fifo_data_in),
    .Fifo_valid_in    (Fifo_valid_in),
    .Fifo_read_en_out (Fifo_read_en_out),
    .Data_out         (Data_out),
    .Valid_out        (Valid_out),
    .Ready_in         (Ready_in),
    .Count_out        (Count_out),
    .Err_out          (Err_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: words owned by the block in delivery order, pops, sticky error.
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] pops;
  logic [CW-1:0] cnt_base;
  logic          exp_err;
  logic          prev_rd;
  logic          flush_prev;
  int            since_rst;

  // Per-test logs.
  int            ncyc;
  int            first_rd;
  int            first_vld;
  int            rd_count;
  logic [DW-1:0] dlog[$];
  logic          vlog[$];
  logic [CW-1:0] clog[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe();
    logic          pop;
    logic          exp_rd;
    logic [CW-1:0] exp_cnt;
    int            room;
    if (!Rst_n_in) begin
      check("rst_valid", Valid_out, 1'b0);
      check("rst_data", Data_out, '0);
      check("rst_count", Count_out, '0);
      check("rst_err", Err_out, 1'b0);
      check("rst_read_en", Fifo_read_en_out, 1'b0);
      exp_q.delete();
      pops       = '0;
      exp_err    = 1'b0;
      prev_rd    = 1'b0;
      flush_prev = 1'b0;
      since_rst  = 0;
    end else begin
      exp_cnt = cnt_base + pops;
      check("valid", Valid_out, exp_q.size() != 0);
      if (exp_q.size() != 0) check("data", Data_out, exp_q[0]);
      check("count", Count_out, exp_cnt);
      check("err", Err_out, exp_err);
      pop    = (exp_q.size() != 0) && Ready_in && !Flush_in;
      room   = exp_q.size() + (prev_rd ? 1 : 0) - (pop ? 1 : 0);
      exp_rd = !Fifo_empty_in && !Flush_in && (room < 2);
      if (since_rst > 0) check("read_en", Fifo_read_en_out, exp_rd);
      else check("read_en_early", Fifo_read_en_out & !exp_rd, 1'b0);
      if (pop) clog.push_back(Count_out);
      if (Flush_in) begin
        exp_q.delete();
        flush_prev = 1'b1;
      end else begin
        if (pop) begin
          void'(exp_q.pop_front());
          pops = pops + 1'b1;
        end
        if (Fifo_valid_in) begin
          if (prev_rd) begin
            if (exp_q.size() >= 2) exp_err = 1'b1;
            else exp_q.push_back(Fifo_data_in);
          end else if (!flush_prev) begin
            exp_err = 1'b1;
          end
        end
        flush_prev = 1'b0;
      end
      prev_rd = Fifo_read_en_out;
      since_rst++;
    end
  endtask

  task automatic cycle();
    logic rd;
    @(negedge Clk);
    observe();
    rd = Fifo_read_en_out;
    if (rd) rd_count++;
    if (rd && first_rd < 0) first_rd = ncyc;
    if (Valid_out && first_vld < 0) first_vld = ncyc;
    dlog.push_back(Data_out);
    vlog.push_back(Valid_out);
    ncyc++;
    @(posedge Clk);
    #1;
    if (rd && src_q.size() > 0) begin
      Fifo_valid_in = 1'b1;
      Fifo_data_in  = src_q.pop_front();
    end else begin
      Fifo_valid_in = 1'b0;
    end
    Fifo_empty_in = (src_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic mark();
    ncyc = 0; first_rd = -1; first_vld = -1; rd_count = 0;
    dlog.delete(); vlog.delete(); clog.delete();
  endtask

  task automatic load(input logic [DW-1:0] w);
    src_q.push_back(w);
    Fifo_empty_in = 1'b0;
  endtask

  task automatic do_reset();
    Rst_n_in      = 1'b0;
    Fifo_valid_in = 1'b0;
    Flush_in      = 1'b0;
    src_q.delete();
    Fifo_empty_in = 1'b1;
    cnt_base      = '0;
    run(2);
    Rst_n_in = 1'b1;
  endtask

  initial begin
    int idx;
    Rst_n_in = 1'b0; Flush_in = 1'b0; Fifo_empty_in = 1'b1; Fifo_data_in = '0;
    Fifo_valid_in = 1'b0; Ready_in = 1'b0;
    pops = '0; cnt_base = '0; exp_err = 1'b0; prev_rd = 1'b0; flush_prev = 1'b0; since_rst = 0;
    mark();
    #1;
    do_reset();

    // Three words, consumer always ready: latency and back-to-back delivery.
    mark();
    Ready_in = 1'b1;
    load(65'h1A); load(65'h2B); load(65'h3C);
    run(10);
    check("lat_rd_to_valid", 32'(first_vld - first_rd), 32'd2);
    idx = (first_vld < 0) ? 0 : first_vld;
    check("seq_w0", dlog[idx], 65'h1A);
    check("seq_v1", vlog[idx + 1], 1'b1);
    check("seq_w1", dlog[idx + 1], 65'h2B);
    check("seq_v2", vlog[idx + 2], 1'b1);
    check("seq_w2", dlog[idx + 2], 65'h3C);
    check("count_after_3", Count_out, 32'd3);

    // Stalled consumer: only two reads may be outstanding.
    mark();
    Ready_in = 1'b0;
    for (int i = 0; i < 5; i++) load(65'h100 + 65'(i));
    run(6);
    check("stall_reads", rd_count, 32'd2);
    check("stall_occ", dut.u_buf.occ, 2'd2);
    check("stall_head", Data_out, 65'h100);
    Ready_in = 1'b1;
    run(10);
    check("drain_count", Count_out, 32'd8);
    check("drain_err", Err_out, 1'b0);

    // Consumer toggling ready every cycle.
    mark();
    for (int i = 0; i < 8; i++) load(65'h1_0000_0000_0000_0000 + 65'(i * 17));
    for (int i = 0; i < 24; i++) begin
      Ready_in = (i % 2) == 0;
      cycle();
    end
    Ready_in = 1'b0;
    run(3);
    check("toggle_pops", clog.size(), 32'd8);
    check("toggle_count", Count_out, 32'd16);

    // Flush while a word is arriving and one is buffered.
    load(65'hA0); load(65'hA1);
    run(2);
    check("pre_flush_occ", dut.u_buf.occ, 2'd1);
    check("pre_flush_vin", Fifo_valid_in, 1'b1);
    Flush_in = 1'b1;
    cycle();
    Flush_in = 1'b0;
    check("flush_occ", dut.u_buf.occ, 2'd0);
    check("flush_valid", Valid_out, 1'b0);
    check("flush_err", Err_out, 1'b0);
    run(4);
    check("flush_count", Count_out, 32'd16);

    // Stray return with nothing in flight: sticky error survives flush, not reset.
    Fifo_valid_in = 1'b1;
    Fifo_data_in  = 65'hEE;
    cycle();
    check("stray_err", Err_out, 1'b1);
    check("stray_valid", Valid_out, 1'b0);
    Flush_in = 1'b1;
    cycle();
    Flush_in = 1'b0;
    run(2);
    check("err_after_flush", Err_out, 1'b1);
    Rst_n_in = 1'b0;
    #1;
    check("err_in_reset", Err_out, 1'b0);
    check("count_in_reset", Count_out, 32'd0);
    do_reset();

    // Counter wrap from a forced preset.
    force dut.count_q = 32'hFFFF_FFFE;
    cnt_base = 32'hFFFF_FFFE - pops;
    cycle();
    release dut.count_q;
    mark();
    Ready_in = 1'b1;
    load(65'h51); load(65'h52); load(65'h53);
    run(8);
    check("wrap_pops", clog.size(), 32'd3);
    check("wrap_c0", clog[0], 32'hFFFF_FFFE);
    check("wrap_c1", clog[1], 32'hFFFF_FFFF);
    check("wrap_c2", clog[2], 32'h0000_0000);
    check("wrap_final", Count_out, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_pop_skid.md
FIFO_POP_SKID -- requirements
Module: fifo_pop_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 65, meaning width of every FIFO entry and output word.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning width of the delivered-word counter.
REQ-003 SHALL have the port list below, clock and reset first: one clock; reset is asynchronous and active-low.
REQ-004 Clk  input  1  single clock for the block, shared with the FIFO read side (RClk).
REQ-005 Rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 Flush_in  input  1  synchronous flush; empties the buffer and discards any in-flight read.
REQ-007 Fifo_empty_in  input  1  FIFO Empty_out.
REQ-008 Fifo_data_in  input  DATA_WIDTH  FIFO Data_out.
REQ-009 Fifo_valid_in  input  1  FIFO Data_valid, one cycle after a granted read.
REQ-010 Fifo_read_en_out  output  1  FIFO ReadEn_in.
REQ-011 Data_out  output  DATA_WIDTH  head word to the consumer.
REQ-012 Valid_out  output  1  Data_out holds a word.
REQ-013 Ready_in  input  1  consumer accepts the word this cycle.
REQ-014 Count_out  output  CNT_WIDTH  total words delivered (Valid_out & Ready_in), wraps modulo 2^CNT_WIDTH.
REQ-015 Err_out  output  1  sticky: Fifo_valid_in arrived with no read in flight, or arrived while the buffer was full.

Function
REQ-016 SHALL hold a 2-entry in-order buffer with a 0..2 occupancy count, plus an inflight flag equal to the previous cycle's Fifo_read_en_out.
REQ-017 pop = Valid_out & Ready_in.
REQ-018 Fifo_read_en_out = !Fifo_empty_in & !Flush_in & ((occ + inflight - pop) < 2). This is combinational and includes a Ready_in-to-read path.
REQ-019 When Fifo_valid_in is high and inflight is high, Fifo_data_in SHALL be written to the buffer tail at that clock edge.
REQ-020 Latency SHALL be 2 cycles: read_en at cycle t, Fifo_valid_in at t+1, Valid_out at t+2.
REQ-021 Valid_out = (occ != 0); Data_out = head entry; Data_out SHALL hold stable while Valid_out & !Ready_in.
REQ-022 Sustained throughput SHALL be 1 word per cycle while the FIFO is non-empty and Ready_in is high.
REQ-023 A simultaneous write and pop SHALL leave occ unchanged, and the order SHALL be preserved.
REQ-024 occ SHALL never exceed 2. A write when occ=2 with no pop SHALL drop the word and set Err_out.
REQ-025 Fifo_valid_in with inflight low SHALL be ignored and SHALL set Err_out.
REQ-026 Flush_in high SHALL, at the next edge, set occ=0 and inflight=0, and SHALL drop any Fifo_valid_in in that cycle and the next.
REQ-027 Flush_in SHALL NOT clear Count_out or Err_out, and pop SHALL be suppressed while Flush_in is high.
REQ-028 Count_out SHALL increment by 1 per pop and wrap from all-ones to 0.

Reset
REQ-029 Rst_n_in low SHALL immediately force: occ=0, inflight=0, Valid_out=0, Data_out=0, Count_out=0, Err_out=0.
REQ-030 Fifo_read_en_out SHALL be 0 while Rst_n_in is low.
REQ-031 After Rst_n_in deasserts, the first read SHALL be issued no earlier than the first clock edge.
REQ-032 A reset asserted mid-transfer SHALL abandon in-flight data; the FIFO's own Clear_in is driven separately.

Structure
REQ-033 A shared package SHALL hold the default DATA_WIDTH (65), CNT_WIDTH (32) and the skid depth constant (2).
REQ-034 The 2-entry buffer SHALL be one sub-module, skid_buf2 (write port, pop port, head output, occupancy); credit logic and counters stay in the top level.

Verification
REQ-035 Empty FIFO pre-loaded with 0x1A, 0x2B, 0x3C and Ready_in=1 -> Valid_out first high 2 cycles after the first read_en; 0x1A, 0x2B, 0x3C on consecutive cycles; Count_out=3.
REQ-036 Ready_in=0 while 5 words are queued -> exactly 2 reads issued, occ=2, Data_out held at word 0; Ready_in=1 -> all 5 delivered in order, no Err_out.
REQ-037 Ready_in toggling 1,0,1,0 over 8 queued words -> no loss, no duplication, order preserved, Count_out=8.
REQ-038 Flush_in pulsed in the same cycle as Fifo_valid_in with occ=1 -> next cycle occ=0, Valid_out=0, word dropped, Err_out=0.
REQ-039 Fifo_valid_in=1 injected with inflight=0 -> Err_out=1 and stays 1 through Flush_in; clears only on Rst_n_in low.
REQ-040 Count_out preset near wrap by forcing 2^CNT_WIDTH-2, then 3 pops -> Count_out reads all-ones-1, all-ones, then 0.
